// File: rtl/bin2bcd_disp_if.sv
// Conversion request/result bundle between a binary source and the BCD display converter.
// The master drives the operand and start; the slave returns the packed BCD result and status.
interface bin2bcd_disp_if #(
   parameter int unsigned WIDTH  = 27,
   parameter int unsigned DIGITS = 8
);
   logic [WIDTH-1:0]    bin_in;
   logic                start;
   logic [4*DIGITS-1:0] disp_data;
   logic                busy;
   logic                done;
   logic                ovf;

   modport master (
      output bin_in,
      output start,
      input  disp_data,
      input  busy,
      input  done,
      input  ovf
   );

   modport slave (
      input  bin_in,
      input  start,
      output disp_data,
      output busy,
      output done,
      output ovf
   );
endinterface

// File: rtl/bin2bcd_disp.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Results saturate to all nines when the operand does not fit in DIGITS decimal digits.
module bin2bcd_disp #(
   parameter int unsigned WIDTH  = 27,
   parameter int unsigned DIGITS = 8
) (
   input logic           clk,
   input logic           rst,
   bin2bcd_disp_if.slave bus
);
   // floor(WIDTH*log10(2))+1 decimal digits always hold 2^WIDTH-1
   localparam int unsigned FULL_D = (WIDTH * 30103) / 100000 + 1;
   localparam int unsigned WORK_D = (FULL_D > DIGITS) ? FULL_D : DIGITS;
   localparam int unsigned WW     = 4 * WORK_D;
   localparam int unsigned CW     = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state;
   logic [WIDTH-1:0] shreg;
   logic [WW-1:0]    work;
   logic [WW-1:0]    work_adj;
   logic [CW-1:0]    cnt;
   logic             over;

   always_comb begin
      work_adj = work;
      for (int unsigned i = 0; i < WORK_D; i++) begin
         if (work[4*i +: 4] >= 4'd5)
            work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
   end

   // Any nonzero digit above the displayed ones means the operand exceeded 10^DIGITS-1
   always_comb begin
      over = 1'b0;
      for (int unsigned i = DIGITS; i < WORK_D; i++) begin
         if (work[4*i +: 4] != 4'd0)
            over = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         shreg         <= '0;
         work          <= '0;
         cnt           <= '0;
         bus.disp_data <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.ovf       <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shreg    <= bus.bin_in;
                  work     <= '0;
                  cnt      <= CW'(WIDTH);
                  bus.busy <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               work  <= WW'({work_adj, shreg[WIDTH-1]});
               shreg <= shreg << 1;
               cnt   <= cnt - 1'b1;
               if (cnt == CW'(1))
                  state <= DONE;
            end
            DONE: begin
               bus.disp_data <= over ? {DIGITS{4'h9}} : work[4*DIGITS-1:0];
               bus.ovf       <= over;
               bus.done      <= 1'b1;
               bus.busy      <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bin2bcd_disp.sv
// Self-checking bench for bin2bcd_disp: cycle-level transaction model plus directed literal checks.
module tb_bin2bcd_disp;
   localparam int unsigned WIDTH  = 27;
   localparam int unsigned DIGITS = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bin2bcd_disp_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
   bin2bcd_disp #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint unsigned dec_limit();
      longint unsigned l = 1;
      for (int i = 0; i < DIGITS; i++) l = l * 10;
      return l - 1;
   endfunction

   // Reference decimal conversion by repeated division, saturating on overflow
   function automatic logic [4*DIGITS-1:0] ref_bcd(input longint unsigned v);
      logic [4*DIGITS-1:0] r = '0;
      if (v > dec_limit()) return {DIGITS{4'h9}};
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   logic                exp_busy = 1'b0;
   logic                exp_done = 1'b0;
   logic                exp_ovf  = 1'b0;
   logic [4*DIGITS-1:0] exp_disp = '0;
   int                  age      = 0;
   longint unsigned     cap      = 0;

   // Transaction model: accept when idle, result appears WIDTH+1 edges after acceptance
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_busy = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0; exp_disp = '0; age = 0;
      end else begin
         exp_done = 1'b0;
         if (!exp_busy) begin
            if (bus.start) begin
               cap = longint'(bus.bin_in); exp_busy = 1'b1; age = 0;
            end
         end else begin
            age++;
            if (age == WIDTH + 1) begin
               exp_busy = 1'b0; exp_done = 1'b1;
               exp_disp = ref_bcd(cap); exp_ovf = (cap > dec_limit());
            end
         end
      end
   end

   always @(posedge clk) begin
      #2;
      check("busy", 64'(bus.busy), 64'(exp_busy));
      check("done", 64'(bus.done), 64'(exp_done));
      check("disp_data", 64'(bus.disp_data), 64'(exp_disp));
      check("ovf", 64'(bus.ovf), 64'(exp_ovf));
   end

   task automatic run_conv(input logic [WIDTH-1:0] v, output int lat, output int bcnt);
      @(negedge clk); bus.bin_in = v; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      bcnt = int'(bus.busy);
      lat  = 0;
      while (lat < 100) begin
         @(posedge clk); #2;
         lat++;
         if (bus.busy) bcnt++;
         if (bus.done) break;
      end
      if (!bus.done) begin
         compared++; mismatched++;
         $display("FAIL conv_timeout: got no done expected done within 100 clocks");
      end
   endtask

   logic [WIDTH-1:0]    bnd_val [4] = '{27'd0, 27'd99999999, 27'd100000000, 27'd134217727};
   logic [4*DIGITS-1:0] bnd_exp [4] = '{32'h00000000, 32'h99999999, 32'h99999999, 32'h99999999};
   logic                bnd_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [WIDTH-1:0]    rvals [1000];

   initial begin
      int lat, bcnt, dones, n;
      bus.start = 1'b0; bus.bin_in = '0;

      // Reset held with start asserted
      @(negedge clk); bus.start = 1'b1; bus.bin_in = 27'd5;
      repeat (20) @(negedge clk);
      check("rst_disp", 64'(bus.disp_data), 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h0);
      rst = 1'b1;
      @(posedge clk); #2;
      check("first_edge_busy", 64'(bus.busy), 64'h1);
      @(negedge clk); bus.start = 1'b0;
      n = 0;
      while (n < 100 && !bus.done) begin @(posedge clk); #2; n++; end
      check("first_result", 64'(bus.disp_data), 64'h5);

      // Nominal conversion
      run_conv(27'd1234567, lat, bcnt);
      check("nom_latency", 64'(lat), 64'd28);
      check("nom_busy_cycles", 64'(bcnt), 64'd28);
      check("nom_disp", 64'(bus.disp_data), 64'h01234567);
      check("nom_ovf", 64'(bus.ovf), 64'h0);
      @(posedge clk); #2;
      check("nom_done_pulse", 64'(bus.done), 64'h0);
      check("nom_hold", 64'(bus.disp_data), 64'h01234567);

      // Boundaries
      for (int i = 0; i < 4; i++) begin
         run_conv(bnd_val[i], lat, bcnt);
         check($sformatf("bnd_disp_%0d", i), 64'(bus.disp_data), 64'(bnd_exp[i]));
         check($sformatf("bnd_ovf_%0d", i), 64'(bus.ovf), 64'(bnd_ovf[i]));
      end

      // Start re-asserted during a conversion and its done cycle
      @(negedge clk); bus.bin_in = 27'd42; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.start = 1'b1; bus.bin_in = 27'd777;
      dones = 0; n = 0;
      while (n < 100 && dones == 0) begin @(posedge clk); #2; n++; if (bus.done) dones++; end
      check("hs_disp", 64'(bus.disp_data), 64'h42);
      @(negedge clk); bus.start = 1'b0;
      repeat (40) begin @(posedge clk); #2; if (bus.done) dones++; end
      check("hs_one_done", 64'(dones), 64'd1);
      run_conv(27'd777, lat, bcnt);
      check("hs_next", 64'(bus.disp_data), 64'h777);

      // Reset part-way through a conversion
      @(negedge clk); rst = 1'b0; #1; @(negedge clk); rst = 1'b1;
      @(negedge clk); bus.bin_in = 27'd87654321; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b0; #1;
      check("midrst_disp", 64'(bus.disp_data), 64'h0);
      check("midrst_busy", 64'(bus.busy), 64'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      dones = 0;
      repeat (40) begin @(posedge clk); #2; if (bus.done) dones++; end
      check("midrst_no_done", 64'(dones), 64'd0);
      check("midrst_disp_after", 64'(bus.disp_data), 64'h0);
      run_conv(27'd87654321, lat, bcnt);
      check("midrst_redo", 64'(bus.disp_data), 64'h87654321);

      // Back-to-back conversions with continuous start
      foreach (rvals[i]) rvals[i] = WIDTH'($urandom);
      @(negedge clk); bus.bin_in = rvals[0]; bus.start = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         n = 0;
         do begin @(posedge clk); #2; n++; end while (!bus.done && n < 100);
         if (i > 0) check("b2b_period", 64'(n), 64'd29);
         check("b2b_disp", 64'(bus.disp_data), 64'(ref_bcd(longint'(rvals[i]))));
         @(negedge clk);
         if (i < 999) bus.bin_in = rvals[i+1];
      end
      bus.start = 1'b0;
      repeat (35) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/bin2bcd_disp.md
BIN2BCD_DISP -- requirements
Module: bin2bcd_disp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 27, which is the binary input width in bits.
REQ-002 The block SHALL have parameter DIGITS, default 8, which is the number of BCD digits produced; disp_data width is 4*DIGITS.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port bin_in, input, WIDTH bits: unsigned binary value to convert, sampled only when a start is accepted.
REQ-006 The block SHALL have port start, input, 1 bit: conversion request, level-sampled each clock.
REQ-007 The block SHALL have port disp_data, output, 4*DIGITS bits: registered packed BCD result, most significant digit in bits [4*DIGITS-1:4*DIGITS-4]; it feeds the digital tube driver's disp_data input directly.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-clock pulse when disp_data has been updated.
REQ-010 The block SHALL have port ovf, output, 1 bit: high when the last accepted bin_in exceeded 10^DIGITS-1.

Function
REQ-011 The conversion SHALL be sequential shift-add-3 (double dabble), processing one input bit per clock, using FSM states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL latch bin_in, clear the internal BCD working register, load bit counter=WIDTH, and enter SHIFT; busy SHALL be 1 from edge k.
REQ-013 In each SHIFT cycle, the block SHALL first add 3 to every working digit that is >=5, then shift the working register left by one, inserting the next binary bit MSB-first; the counter SHALL decrement, and when it reaches 0 the FSM SHALL enter DONE.
REQ-014 SHIFT SHALL occupy edges k+1..k+WIDTH.
REQ-015 At edge k+WIDTH+1 (DONE), the block SHALL load disp_data, set done=1, clear busy, and return to IDLE; done SHALL return to 0 at the next edge.
REQ-016 Total latency from start sampled to done high SHALL be WIDTH+1 clocks (28 at defaults).
REQ-017 The working register SHALL be wide enough to hold the full double-dabble result of 2^WIDTH-1 without truncation; no intermediate digit SHALL exceed 9 after correction.
REQ-018 Overflow: if the latched value exceeds 10^DIGITS-1, then at DONE disp_data SHALL be all digits 9 (0x99999999 at defaults) and ovf=1; otherwise ovf=0; ovf SHALL update only at DONE.
REQ-019 start SHALL be ignored while busy=1 and during the DONE cycle; bin_in changes during a conversion SHALL have no effect.
REQ-020 start held high continuously SHALL produce back-to-back conversions, each re-sampling bin_in in IDLE.
REQ-021 disp_data and ovf SHALL hold their last values between conversions.

Reset
REQ-022 On rst=0, immediately and regardless of clk, the FSM SHALL go to IDLE, disp_data SHALL be 0, and busy, done and ovf SHALL be 0; the working register and counter SHALL clear.
REQ-023 A reset mid-conversion SHALL abandon the conversion with no done pulse, and disp_data SHALL remain 0 after release.
REQ-024 The first start SHALL be accepted at the first rising edge with rst=1.

Verification
REQ-025 Reset: rst=0 for 20 clocks with start=1 -> disp_data=0x00000000, busy=0, done=0, ovf=0 throughout; after release, a conversion begins at the first edge.
REQ-026 Nominal: bin_in=1234567 (decimal), start pulsed one clock -> busy high for 28 clocks, done a single pulse at clock 28, disp_data=0x01234567, ovf=0.
REQ-027 Boundaries: bin_in=0 -> 0x00000000; bin_in=99999999 -> 0x99999999 with ovf=0; bin_in=100000000 -> 0x99999999 with ovf=1; bin_in=134217727 -> 0x99999999 with ovf=1.
REQ-028 Handshake: with bin_in=42, start, then start and bin_in=777 re-asserted mid-conversion and during the done cycle -> exactly one done pulse, disp_data=0x00000042; the next start in IDLE yields 0x00000777.
REQ-029 Mid-operation reset: start with bin_in=87654321, then rst=0 at clock 10 -> no done pulse and disp_data=0; after release, start with bin_in=87654321 -> 0x87654321.
REQ-030 Continuous start with bin_in stepping every conversion through a 1000-value random set -> done every 29 clocks, and each disp_data matches the reference decimal conversion.
